// File: rtl/instr_feeder_pkg.sv
// Shared types for the instruction feeder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package feeder_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    GAP   = 3'd3,
    ERR   = 3'd4
  } feeder_state_t;

  // Watchdog counter width; wide enough for any practical TIMEOUT.
  localparam int WDOG_W = 16;

endpackage

// File: rtl/instr_feeder_if.sv
// Host program/control port plus core instruction port of the feeder.
// Latency: n/a (wiring only).
// Backpressure: core paces the feeder through done; host writes drop while busy.
interface instr_feeder_if #(
  parameter int AW = 5
) ();

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          start;
  logic [AW:0]   len;
  logic [15:0]   din;
  logic          run;
  logic          done;
  logic          busy;
  logic          finished;
  logic          error;
  logic [AW-1:0] pc;

  // Feeder side: drives the core and reports status.
  modport master (
    input  wr_en, wr_addr, wr_data, start, len, done,
    output din, run, busy, finished, error, pc
  );

  // Host/core side.
  modport slave (
    output wr_en, wr_addr, wr_data, start, len, done,
    input  din, run, busy, finished, error, pc
  );

endinterface

// File: rtl/instr_feeder_ram.sv
// Program store: DEPTH x 16, synchronous write, asynchronous read, no reset.
// Latency: write visible to reads the cycle after the write edge; read is combinational.
// Backpressure: none; the caller gates the write enable.
module feeder_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  // Host write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_feeder.sv
// Program sequencer: issues RAM words to the core one at a time, with a watchdog.
// Latency: start -> run 1 cycle; done -> next run 2 cycles; final done -> finished 1 cycle.
// Backpressure: each word is held until the core's done; start/writes ignored while busy.
module instr_feeder
  import feeder_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 64
) (
  input logic            clk,
  input logic            reset,
  instr_feeder_if.master bus
);

  feeder_state_t     state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [AW:0]       len_q, len_d;
  logic [15:0]       din_q, din_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              run_q, run_d;
  logic              fin_q, fin_d;
  logic              err_q, err_d;

  logic              busy;
  logic [AW-1:0]     rd_addr;
  logic [15:0]       rd_data;

  assign busy = (state_q == ISSUE) || (state_q == WAIT) || (state_q == GAP);

  // Only WAIT needs the next word; otherwise address 0 is presented for start.
  assign rd_addr = (state_q == WAIT) ? pc_q + AW'(1) : '0;

  // Asynchronous read means a same-cycle start sees mem[0] before a write lands.
  feeder_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (bus.wr_en && !busy),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    din_d   = din_q;
    wdog_d  = wdog_q;
    run_d   = 1'b0;
    fin_d   = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE, ERR: begin
        if (bus.start) begin
          err_d   = 1'b0;
          state_d = IDLE;
          if (bus.len == '0) begin
            fin_d = 1'b1;
          end else begin
            len_d   = bus.len;
            pc_d    = '0;
            din_d   = rd_data;
            run_d   = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_q + WDOG_W'(1);
        if (bus.done) begin
          if ({1'b0, pc_q} == len_q - (AW+1)'(1)) begin
            fin_d   = 1'b1;
            state_d = IDLE;
          end else begin
            pc_d    = pc_q + AW'(1);
            din_d   = rd_data;
            state_d = GAP;
          end
        end else if (wdog_q == WDOG_W'(TIMEOUT - 2)) begin
          // Incremented count reaches TIMEOUT-1: error lands TIMEOUT cycles after run.
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      GAP: begin
        run_d   = 1'b1;
        state_d = ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      din_q   <= '0;
      wdog_q  <= '0;
      run_q   <= 1'b0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      din_q   <= din_d;
      wdog_q  <= wdog_d;
      run_q   <= run_d;
      fin_q   <= fin_d;
      err_q   <= err_d;
    end
  end

  assign bus.din      = din_q;
  assign bus.run      = run_q;
  assign bus.busy     = busy;
  assign bus.finished = fin_q;
  assign bus.error    = err_q;
  assign bus.pc       = pc_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Directed self-checking bench for instr_feeder (TIMEOUT=8).
// Latency: inputs driven 1ns after the rising edge, outputs sampled there too.
// Backpressure: core done pulses are scripted per word.
module tb_instr_feeder;

  localparam int DEPTH   = 32;
  localparam int AW      = 5;
  localparam int TIMEOUT = 8;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  instr_feeder_if #(.AW(AW)) bus ();

  instr_feeder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [AW-1:0] addr, input logic [15:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic start_run(input logic [AW:0] n);
    bus.start = 1'b1;
    bus.len   = n;
    tick();
    bus.start = 1'b0;
  endtask

  // Entered at a run cycle; core answers done two cycles after run.
  // Non-last: returns at the next run cycle. Last: returns at the finished cycle.
  task automatic issue_word(input logic [15:0] exp_din, input int exp_pc, input bit last);
    check("run_issue", bus.run, 1);
    check("din_issue", bus.din, exp_din);
    check("pc_issue", bus.pc, exp_pc);
    check("busy_issue", bus.busy, 1);
    tick();
    check("run_wait", bus.run, 0);
    tick();
    check("din_hold", bus.din, exp_din);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    if (last) begin
      check("finished", bus.finished, 1);
      check("busy_end", bus.busy, 0);
      check("run_end", bus.run, 0);
    end else begin
      check("run_gap", bus.run, 0);
      check("fin_gap", bus.finished, 0);
      check("pc_next", bus.pc, exp_pc + 1);
      check("busy_gap", bus.busy, 1);
      tick();
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    bus.len     = '0;
    bus.done    = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    check("rst_din", bus.din, 0);
    check("rst_run", bus.run, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_fin", bus.finished, 0);
    check("rst_err", bus.error, 0);
    check("rst_pc", bus.pc, 0);

    // Basic three-word program.
    write_word(0, 16'h1111);
    write_word(1, 16'h2222);
    write_word(2, 16'h3333);
    start_run(3);
    issue_word(16'h1111, 0, 0);
    issue_word(16'h2222, 1, 0);
    issue_word(16'h3333, 2, 1);
    tick();
    check("fin_single", bus.finished, 0);
    check("busy_after", bus.busy, 0);

    // Zero-length start.
    start_run(0);
    check("len0_fin", bus.finished, 1);
    check("len0_run", bus.run, 0);
    check("len0_busy", bus.busy, 0);
    tick();
    check("len0_fin_drop", bus.finished, 0);
    check("len0_run2", bus.run, 0);

    // Watchdog: no done at all.
    start_run(3);
    check("wd_run", bus.run, 1);
    for (int i = 1; i < TIMEOUT; i++) tick();
    check("wd_err_early", bus.error, 0);
    check("wd_busy_early", bus.busy, 1);
    tick();
    check("wd_err", bus.error, 1);
    check("wd_busy", bus.busy, 0);
    tick();
    check("wd_sticky", bus.error, 1);
    start_run(1);
    check("wd_clear", bus.error, 0);
    issue_word(16'h1111, 0, 1);

    // Write while busy is dropped.
    start_run(2);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 1;
    bus.wr_data = 16'hBEEF;
    tick();
    bus.wr_en = 1'b0;
    bus.done  = 1'b1;
    tick();
    bus.done = 1'b0;
    check("drop_gap_din", bus.din, 16'h2222);
    check("drop_gap_run", bus.run, 0);
    tick();
    issue_word(16'h2222, 1, 1);
    start_run(2);
    issue_word(16'h1111, 0, 0);
    issue_word(16'h2222, 1, 1);

    // Reset during WAIT of the second word, with done outstanding.
    start_run(3);
    issue_word(16'h1111, 0, 0);
    tick();
    reset    = 1'b1;
    bus.done = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_din", bus.din, 0);
    check("mid_rst_run", bus.run, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_pc", bus.pc, 0);
    check("mid_rst_fin", bus.finished, 0);
    check("mid_rst_err", bus.error, 0);
    tick();
    bus.done = 1'b0;
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_fin", bus.finished, 0);
    start_run(3);
    issue_word(16'h1111, 0, 0);
    issue_word(16'h2222, 1, 0);
    issue_word(16'h3333, 2, 1);

    // done coincident with run is ignored.
    start_run(1);
    check("coin_run", bus.run, 1);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("coin_busy", bus.busy, 1);
    check("coin_fin", bus.finished, 0);
    tick();
    tick();
    check("coin_still", bus.busy, 1);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("coin_done_fin", bus.finished, 1);
    check("coin_done_busy", bus.busy, 0);

    // Write and start in the same cycle: old mem[0] issued, write lands.
    bus.wr_en   = 1'b1;
    bus.wr_addr = 0;
    bus.wr_data = 16'hAAAA;
    start_run(1);
    bus.wr_en = 1'b0;
    issue_word(16'h1111, 0, 1);
    start_run(1);
    issue_word(16'hAAAA, 0, 1);

    // Full-depth program: addresses 0..DEPTH-1, no wrap.
    for (int i = 0; i < DEPTH; i++) write_word(AW'(i), 16'hA000 + 16'(i));
    start_run((AW+1)'(DEPTH));
    for (int i = 0; i < DEPTH; i++) issue_word(16'hA000 + 16'(i), i, (i == DEPTH - 1));
    tick();
    check("full_busy", bus.busy, 0);
    check("full_err", bus.error, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
